// File: rtl/vga_timing_gen.sv
// Programmable VGA raster timing: pixel-rate divider, h/v counters and
// registered sync, display-enable, coordinate and line/frame pulse outputs.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 2,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enable,
    output logic          pix_en,
    output logic          h_sync,
    output logic          v_sync,
    output logic          display_en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int XE      = XW + 1;
    localparam int YE      = YW + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);

    // One extra bit so sync-end bounds equal to 2^XW still compare correctly
    localparam logic [XE-1:0] H_ACT = XE'(H_ACTIVE);
    localparam logic [XE-1:0] H_SS  = XE'(H_ACTIVE + H_FP);
    localparam logic [XE-1:0] H_SE  = XE'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YE-1:0] V_ACT = YE'(V_ACTIVE);
    localparam logic [YE-1:0] V_SS  = YE'(V_ACTIVE + V_FP);
    localparam logic [YE-1:0] V_SE  = YE'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    if ((2 ** XW) < H_TOTAL) begin : g_bad_xw
        $error("XW too narrow for H_TOTAL");
    end
    if ((2 ** YW) < V_TOTAL) begin : g_bad_yw
        $error("YW too narrow for V_TOTAL");
    end
    if (CLK_DIV < 1) begin : g_bad_div
        $error("CLK_DIV must be at least 1");
    end

    logic [DW-1:0] r_div;
    logic [XW-1:0] r_h;
    logic [YW-1:0] r_v;
    logic          r_pix_en;
    logic          r_hs;
    logic          r_vs;
    logic          r_de;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_ls;
    logic          r_fs;

    logic          w_stb;
    logic          w_h_last;
    logic          w_v_last;
    logic [XE-1:0] w_h_ext;
    logic [YE-1:0] w_v_ext;
    logic          w_active;
    logic          w_hs_act;
    logic          w_vs_act;

    assign w_stb    = enable && (r_div == DIV_LAST);
    assign w_h_last = (r_h == H_LAST);
    assign w_v_last = (r_v == V_LAST);
    assign w_h_ext  = {1'b0, r_h};
    assign w_v_ext  = {1'b0, r_v};
    assign w_active = (w_h_ext < H_ACT) && (w_v_ext < V_ACT);
    assign w_hs_act = (w_h_ext >= H_SS) && (w_h_ext < H_SE);
    assign w_vs_act = (w_v_ext >= V_SS) && (w_v_ext < V_SE);

    // Counters hold the position presented at the next strobe, so the first
    // strobe after enable shows the origin together with frame_start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div    <= '0;
            r_h      <= '0;
            r_v      <= '0;
            r_pix_en <= 1'b0;
            r_hs     <= ~HS_ON;
            r_vs     <= ~VS_ON;
            r_de     <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_ls     <= 1'b0;
            r_fs     <= 1'b0;
        end else if (!enable) begin
            r_div    <= '0;
            r_h      <= '0;
            r_v      <= '0;
            r_pix_en <= 1'b0;
            r_hs     <= ~HS_ON;
            r_vs     <= ~VS_ON;
            r_de     <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_ls     <= 1'b0;
            r_fs     <= 1'b0;
        end else begin
            r_pix_en <= w_stb;
            r_ls     <= 1'b0;
            r_fs     <= 1'b0;
            if (w_stb) begin
                r_div <= '0;
                r_x   <= r_h;
                r_y   <= r_v;
                r_de  <= w_active;
                r_hs  <= w_hs_act ? HS_ON : ~HS_ON;
                r_vs  <= w_vs_act ? VS_ON : ~VS_ON;
                r_ls  <= (r_h == '0);
                r_fs  <= (r_h == '0) && (r_v == '0);
                if (w_h_last) begin
                    r_h <= '0;
                    r_v <= w_v_last ? '0 : r_v + YW'(1);
                end else begin
                    r_h <= r_h + XW'(1);
                end
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

    assign pix_en      = r_pix_en;
    assign h_sync      = r_hs;
    assign v_sync      = r_vs;
    assign display_en  = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_ls;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, mid-size and tiny configurations checked
// against an arithmetic raster model driven by clocks-since-enable.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d, en_d, rst_m, en_m, rst_t, en_t;

    logic pe_d, hs_d, vs_d, de_d, ls_d, fs_d;
    logic [9:0] x_d, y_d;
    logic pe_m, hs_m, vs_m, de_m, ls_m, fs_m;
    logic [9:0] x_m, y_m;
    logic pe_t, hs_t, vs_t, de_t, ls_t, fs_t;
    logic [9:0] x_t, y_t;

    int checks = 0;
    int failures = 0;
    int t_d, t_m, t_t;

    wire [25:0] o_d = {pe_d, hs_d, vs_d, de_d, ls_d, fs_d, x_d, y_d};
    wire [25:0] o_m = {pe_m, hs_m, vs_m, de_m, ls_m, fs_m, x_m, y_m};
    wire [25:0] o_t = {pe_t, hs_t, vs_t, de_t, ls_t, fs_t, x_t, y_t};

    vga_timing_gen u_def (
        .clk(clk), .reset_n(rst_d), .enable(en_d),
        .pix_en(pe_d), .h_sync(hs_d), .v_sync(vs_d),
        .display_en(de_d), .x(x_d), .y(y_d),
        .line_start(ls_d), .frame_start(fs_d)
    );

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .HS_POL(1), .VS_POL(0), .CLK_DIV(3)
    ) u_mid (
        .clk(clk), .reset_n(rst_m), .enable(en_m),
        .pix_en(pe_m), .h_sync(hs_m), .v_sync(vs_m),
        .display_en(de_m), .x(x_m), .y(y_m),
        .line_start(ls_m), .frame_start(fs_m)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1), .VS_POL(1), .CLK_DIV(1)
    ) u_tiny (
        .clk(clk), .reset_n(rst_t), .enable(en_t),
        .pix_en(pe_t), .h_sync(hs_t), .v_sync(vs_t),
        .display_en(de_t), .x(x_t), .y(y_t),
        .line_start(ls_t), .frame_start(fs_t)
    );

    // Clock edges seen with reset released and enable high
    always @(posedge clk or negedge rst_d)
        if (!rst_d) t_d <= 0; else if (!en_d) t_d <= 0; else t_d <= t_d + 1;
    always @(posedge clk or negedge rst_m)
        if (!rst_m) t_m <= 0; else if (!en_m) t_m <= 0; else t_m <= t_m + 1;
    always @(posedge clk or negedge rst_t)
        if (!rst_t) t_t <= 0; else if (!en_t) t_t <= 0; else t_t <= t_t + 1;

    // After t enabled clocks, n = t/d strobes have happened; strobe k shows
    // raster position k-1 (mod frame size).
    function automatic logic [25:0] ref_out(
        input int t, input int ha, input int hfp, input int hsw, input int hbp,
        input int va, input int vfp, input int vsw, input int vbp,
        input int hpol, input int vpol, input int d);
        int ht, vt, n, p, px, py;
        logic hp, vp, pe, de, hsa, vsa;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        hp = (hpol != 0);
        vp = (vpol != 0);
        n = t / d;
        if (n == 0) return {1'b0, ~hp, ~vp, 3'b000, 20'd0};
        p = (n - 1) % (ht * vt);
        px = p % ht;
        py = p / ht;
        pe = ((t % d) == 0);
        de = (px < ha) && (py < va);
        hsa = (px >= ha + hfp) && (px < ha + hfp + hsw);
        vsa = (py >= va + vfp) && (py < va + vfp + vsw);
        return {pe, hsa ? hp : ~hp, vsa ? vp : ~vp, de,
                pe && (px == 0), pe && (px == 0) && (py == 0),
                px[9:0], py[9:0]};
    endfunction

    function automatic logic [25:0] ref_d(input int t);
        return ref_out(t, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2);
    endfunction
    function automatic logic [25:0] ref_m(input int t);
        return ref_out(t, 20, 3, 5, 4, 10, 2, 3, 2, 1, 0, 3);
    endfunction
    function automatic logic [25:0] ref_t(input int t);
        return ref_out(t, 4, 1, 2, 1, 2, 1, 1, 1, 1, 1, 1);
    endfunction

    task automatic test_reset();
        rst_d = 1'b0; rst_m = 1'b0; rst_t = 1'b0;
        en_d = 1'b1; en_m = 1'b1; en_t = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (o_d !== {1'b0, 1'b1, 1'b1, 3'b000, 20'd0}) begin
            failures++;
            $display("FAIL reset_def got=%h exp=%h", o_d,
                     {1'b0, 1'b1, 1'b1, 3'b000, 20'd0});
        end
        checks++;
        if (o_m !== {1'b0, 1'b0, 1'b1, 3'b000, 20'd0}) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=%h", o_m,
                     {1'b0, 1'b0, 1'b1, 3'b000, 20'd0});
        end
        checks++;
        if (o_t !== {1'b0, 1'b0, 1'b0, 3'b000, 20'd0}) begin
            failures++;
            $display("FAIL reset_tiny got=%h exp=%h", o_t,
                     {1'b0, 1'b0, 1'b0, 3'b000, 20'd0});
        end
    endtask

    task automatic test_defaults();
        int last_ls, nhs, nde;
        last_ls = -1; nhs = 0; nde = 0;
        rst_d = 1'b1;
        for (int i = 0; i < 4900; i++) begin
            @(negedge clk);
            checks++;
            if (o_d !== ref_d(t_d)) begin
                failures++;
                $display("FAIL def_model t=%0d got=%h exp=%h", t_d, o_d, ref_d(t_d));
            end
            checks++;
            if (pe_d !== ((i % 2) == 1)) begin
                failures++;
                $display("FAIL def_pix_en i=%0d got=%b", i, pe_d);
            end
            if (pe_d && ls_d) begin
                if (last_ls >= 0) begin
                    checks += 3;
                    if (i - last_ls != 1600) begin
                        failures++;
                        $display("FAIL ls_period got=%0d exp=1600", i - last_ls);
                    end
                    if (nhs != 96) begin
                        failures++;
                        $display("FAIL hs_width got=%0d exp=96", nhs);
                    end
                    if (nde != 640) begin
                        failures++;
                        $display("FAIL de_per_line got=%0d exp=640", nde);
                    end
                end
                last_ls = i; nhs = 0; nde = 0;
            end
            if (pe_d && !hs_d) begin
                nhs++;
                checks++;
                if (x_d < 10'd656 || x_d > 10'd751) begin
                    failures++;
                    $display("FAIL hs_range x=%0d exp=656..751", x_d);
                end
            end
            if (pe_d && de_d) nde++;
        end
    endtask

    task automatic test_enable_drop();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            checks++;
            if (o_d !== ref_d(t_d)) begin
                failures++;
                $display("FAIL drop_model t=%0d got=%h exp=%h", t_d, o_d, ref_d(t_d));
            end
            if (pe_d && x_d == 10'd300 && y_d == 10'd4) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL drop_wait got=timeout exp=x300_y4");
            return;
        end
        en_d = 1'b0;
        @(negedge clk);
        checks++;
        if ({x_d, y_d, hs_d, vs_d, de_d} !== {10'd0, 10'd0, 3'b110}) begin
            failures++;
            $display("FAIL drop_clear got=%h exp=%h", {x_d, y_d, hs_d, vs_d, de_d},
                     {10'd0, 10'd0, 3'b110});
        end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (o_d !== ref_d(t_d)) begin
                failures++;
                $display("FAIL drop_hold got=%h exp=%h", o_d, ref_d(t_d));
            end
        end
        en_d = 1'b1;
        @(negedge clk);
        checks++;
        if (pe_d !== 1'b0) begin
            failures++;
            $display("FAIL drop_early_pe got=%b exp=0", pe_d);
        end
        @(negedge clk);
        checks++;
        if ({pe_d, fs_d, x_d, y_d} !== {2'b11, 20'd0}) begin
            failures++;
            $display("FAIL drop_restart got=%h exp=%h", {pe_d, fs_d, x_d, y_d},
                     {2'b11, 20'd0});
        end
    endtask

    task automatic test_tiny();
        int px, last_fs;
        px = 0; last_fs = -1;
        rst_t = 1'b1;
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            checks++;
            if (o_t !== ref_t(t_t)) begin
                failures++;
                $display("FAIL tiny_model t=%0d got=%h exp=%h", t_t, o_t, ref_t(t_t));
            end
            checks += 3;
            if (pe_t !== 1'b1) begin
                failures++;
                $display("FAIL tiny_pe got=%b exp=1", pe_t);
            end
            if (hs_t !== (x_t == 10'd5 || x_t == 10'd6)) begin
                failures++;
                $display("FAIL tiny_hs x=%0d got=%b", x_t, hs_t);
            end
            if (vs_t !== (y_t == 10'd3)) begin
                failures++;
                $display("FAIL tiny_vs y=%0d got=%b", y_t, vs_t);
            end
            if (i > 0) begin
                checks++;
                if (x_t !== 10'((px + 1) % 8)) begin
                    failures++;
                    $display("FAIL tiny_x_seq got=%0d exp=%0d", x_t, (px + 1) % 8);
                end
            end
            px = int'(x_t);
            if (fs_t) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (i - last_fs != 40) begin
                        failures++;
                        $display("FAIL tiny_fs_period got=%0d exp=40", i - last_fs);
                    end
                end
                last_fs = i;
            end
        end
    endtask

    task automatic test_random_enable();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            checks++;
            if (o_t !== ref_t(t_t)) begin
                failures++;
                $display("FAIL rand_en t=%0d got=%h exp=%h", t_t, o_t, ref_t(t_t));
            end
            en_t = ($urandom_range(0, 9) != 0);
        end
        en_t = 1'b1;
    endtask

    task automatic test_wrap();
        bit found;
        found = 1'b0;
        rst_m = 1'b1;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            checks++;
            if (o_m !== ref_m(t_m)) begin
                failures++;
                $display("FAIL wrap_model t=%0d got=%h exp=%h", t_m, o_m, ref_m(t_m));
            end
            if (pe_m && x_m == 10'd31 && y_m == 10'd16) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL wrap_wait got=timeout exp=x31_y16");
            return;
        end
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            if (pe_m) found = 1'b1;
        end
        checks++;
        if (!found || {x_m, y_m, ls_m, fs_m} !== {20'd0, 2'b11}) begin
            failures++;
            $display("FAIL wrap_origin got=%h exp=%h", {x_m, y_m, ls_m, fs_m},
                     {20'd0, 2'b11});
        end
    endtask

    task automatic test_async_reset();
        bit found, seen;
        found = 1'b0; seen = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (y_m == 10'd8) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL arst_wait got=timeout exp=y8");
            return;
        end
        repeat ($urandom_range(0, 40)) @(negedge clk);
        @(posedge clk);
        #2 rst_m = 1'b0;
        #1;
        checks++;
        if (o_m !== {1'b0, 1'b0, 1'b1, 3'b000, 20'd0}) begin
            failures++;
            $display("FAIL arst_immediate got=%h exp=%h", o_m,
                     {1'b0, 1'b0, 1'b1, 3'b000, 20'd0});
        end
        @(negedge clk);
        rst_m = 1'b1;
        for (int i = 0; i < 1700; i++) begin
            @(negedge clk);
            checks++;
            if (o_m !== ref_m(t_m)) begin
                failures++;
                $display("FAIL arst_model t=%0d got=%h exp=%h", t_m, o_m, ref_m(t_m));
            end
            if (pe_m && !seen) begin
                seen = 1'b1;
                checks++;
                if (i != 2 || {fs_m, x_m, y_m} !== {1'b1, 20'd0}) begin
                    failures++;
                    $display("FAIL arst_restart i=%0d got=%h exp=%h", i,
                             {fs_m, x_m, y_m}, {1'b1, 20'd0});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_enable_drop();
        test_tiny();
        test_random_enable();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator that replaces the fixed 768-count sync logic with a fully programmable horizontal/vertical timing set. It divides the system clock into a pixel-enable strobe and runs pixel/line counters. It produces registered h/v sync with selectable polarity, a display-enable window, pixel coordinates, and line/frame start pulses. It sits between the board clock and the pixel/colour logic (border, paddles, ball) of the pong top level.

## Interface

**Parameters**
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, h_sync active level (0 = active-low)
- VS_POL, 0, v_sync active level (0 = active-low)
- CLK_DIV, 2, clk cycles per pixel (≥1)
- XW, 10, width of x output
- YW, 10, width of y output

**Ports**
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  run/hold; low forces counters to origin
- pix_en  out  1  one-clk pixel strobe
- h_sync  out  1  horizontal sync, polarity HS_POL
- v_sync  out  1  vertical sync, polarity VS_POL
- display_en  out  1  high inside active area
- x  out  XW  current pixel column (0..H_TOTAL-1)
- y  out  YW  current line (0..V_TOTAL-1)
- line_start  out  1  one-clk pulse at h=0
- frame_start  out  1  one-clk pulse at h=0, v=0

## Operation

- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Elaboration must fail if 2^XW < H_TOTAL, 2^YW < V_TOTAL, or CLK_DIV < 1.
- Divider: counter 0..CLK_DIV-1 increments every clk while enable=1. Internal strobe is high when the counter equals CLK_DIV-1, then the counter wraps to 0. When CLK_DIV=1, the strobe is constantly high.
- h_cnt advances on the strobe. At H_TOTAL-1 it wraps to 0 and v_cnt advances. v_cnt wraps to 0 after V_TOTAL-1.
- Decode, evaluated on the current h_cnt/v_cnt:
  - active: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
  - hs_act: H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_act: V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC. This is line-based and changes at the h wrap.
- Output mapping:
  - h_sync = hs_act ? HS_POL : ~HS_POL.
  - v_sync = vs_act ? VS_POL : ~VS_POL.
- line_start is high for the one clk following the strobe that loaded h_cnt=0. frame_start is the same condition with v_cnt=0 also true. Both are single clk wide regardless of CLK_DIV.
- When enable=0, the divider, h_cnt and v_cnt clear synchronously to 0. From the next clk, outputs hold their reset values.
- When enable rises, the first pix_en appears CLK_DIV clks later. The outputs then present (0,0) with frame_start=1.

## Timing

- Reset values (async on reset_n low):
  - Counters: all 0.
  - pix_en=0, display_en=0, x=0, y=0, line_start=0, frame_start=0.
  - h_sync=~HS_POL, v_sync=~VS_POL.
- All outputs are registered. pix_en is high for the single clk in which x/y/syncs/display_en/pulses take their new values. These outputs then hold stable until the next pix_en.
- Latency: from a strobe advancing the counters to the outputs reflecting the new value is exactly 1 clk. All outputs are mutually aligned with no skew.
- Frame period: H_TOTAL·V_TOTAL·CLK_DIV clks. For the defaults this is 840000.
- Reset released mid-frame restarts from origin; there is no partial-frame resume.
- Simultaneous h wrap and v wrap: x=0, y=0, line_start=1 and frame_start=1 all appear in the same clk.

## Test plan

- **Defaults, CLK_DIV=2:** release reset_n, hold enable=1. Required: pix_en toggles every 2nd clk; frame_start pulses every 840000 clks; line_start pulses every 1600 clks.
- **Defaults, sync decode:**
  - h_sync is low exactly for x=656..751, i.e. 96 pixels.
  - v_sync is low exactly for y=490..491.
  - display_en is high only for x<640 and y<480. Count exactly 307200 enabled pixels per frame.
- **Tiny config:** H 4/1/2/1 (total 8), V 2/1/1/1 (total 5), CLK_DIV=1, HS_POL=VS_POL=1. Required:
  - x cycles 0..7 every clk.
  - h_sync is high at x=5,6.
  - v_sync is high for all 8 pixels of y=3.
  - frame_start recurs every 40 clks.
- **Enable drop mid-line:** at x=300, y=100, drive enable=0 for 5 clks, then 1. Required:
  - Next clk: x=0, y=0, syncs inactive, display_en=0.
  - 2 clks after enable=1: pix_en=1 with frame_start=1 and x=y=0.
- **Async reset mid-frame:** assert reset_n=0 off a clk edge at y=200. Outputs must go to their reset values immediately, without waiting for a clk edge. After release, the frame restarts at origin.
- **Last-pixel wrap:** observe x=799, y=524, then the next pix_en. Required: x=0, y=0, line_start=1 and frame_start=1 in the same clk.
